demux32_1_2: RTL and testbench

Registered 1-to-2 word demultiplexer: the routing counterpart of the 32-bit 2:1 select mux. It steers each accepted 32-bit input word to one of two output channels chosen by a select bit. Each channel buffers words in its own small FIFO behind a valid/ready handshake. It sits on datapath fan-out points, such as splitting a result bus between a writeback path and a store path, where the two consumers can stall independently.

---
 rtl/demux32_1_2.sv | 104 ++++++++++
 tb/tb_demux32_1_2.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/demux32_1_2.sv
// Registered 1-to-2 word demultiplexer with a small FIFO per output channel.
// Optional per-channel push counters are enabled by defining DEMUX32_1_2_STATS_EN.
module demux32_1_2 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    count_q  [2];
  logic [PW-1:0]    rd_ptr_q [2];
  logic [PW-1:0]    wr_ptr_q [2];
  logic [WIDTH-1:0] mem_q    [2][DEPTH];

  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] valid;
  logic [1:0] ready;

  // Full channels refuse input even when popping this cycle: no pass-through path.
  assign in_ready = s ? (count_q[1] != CW'(DEPTH)) : (count_q[0] != CW'(DEPTH));
  assign ready    = {out1_ready, out0_ready};

  always_comb begin
    push  = '0;
    pop   = '0;
    valid = '0;
    for (int c = 0; c < 2; c++) begin
      valid[c] = (count_q[c] != '0);
      pop[c]   = valid[c] && ready[c];
      push[c]  = in_valid && in_ready && (s == c[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        count_q[c]  <= '0;
        rd_ptr_q[c] <= '0;
        wr_ptr_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PW'(1);
        if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + PW'(1);
        if (push[c] && !pop[c]) begin
          count_q[c] <= count_q[c] + CW'(1);
        end else if (pop[c] && !push[c]) begin
          count_q[c] <= count_q[c] - CW'(1);
        end
      end
    end
  end

  // Storage needs no reset: contents are only visible while the count is non-zero.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= in_data;
    end
  end

  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out0_data  = mem_q[0][rd_ptr_q[0]];
  assign out1_data  = mem_q[1][rd_ptr_q[1]];

`ifdef DEMUX32_1_2_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (push[0] && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (push[1] && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux32_1_2.sv
// Bench for demux32_1_2: directed scenarios plus random traffic checked against
// a queue-per-channel reference model.
module tb_demux32_1_2;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out0_valid, out1_valid;
  logic        out0_ready, out1_ready;
  logic [31:0] out0_data, out1_data;
  logic [15:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          exp_cnt[2];

  always #5 clk = ~clk;

  demux32_1_2 #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (s),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
  task automatic cycle(input logic v, input logic sel, input logic [31:0] d,
                       input logic r0, input logic r1, input logic rn, output logic acc);
    int  sz_sel;
    logic p0, p1;
    logic [31:0] stats_exp0, stats_exp1;
    @(negedge clk);
    rst_n = rn; in_valid = v; s = sel; in_data = d; out0_ready = r0; out1_ready = r1;
    #1;
    sz_sel = sel ? q1.size() : q0.size();
    check("in_ready", {31'd0, in_ready}, {31'd0, sz_sel != DEPTH});
    check("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
    check("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
    if (q0.size() != 0) check("out0_data", out0_data, q0[0]);
    if (q1.size() != 0) check("out1_data", out1_data, q1[0]);
`ifdef DEMUX32_1_2_STATS_EN
    stats_exp0 = exp_cnt[0];
    stats_exp1 = exp_cnt[1];
`else
    stats_exp0 = 0;
    stats_exp1 = 0;
`endif
    check("cnt0", {16'd0, cnt0}, stats_exp0);
    check("cnt1", {16'd0, cnt1}, stats_exp1);
    acc = v && (sz_sel != DEPTH);
    p0  = r0 && q0.size() != 0;
    p1  = r1 && q1.size() != 0;
    @(posedge clk);
    if (!rn) begin
      q0.delete();
      q1.delete();
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      acc = 1'b0;
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (sel) q1.push_back(d);
        else     q0.push_back(d);
        if (exp_cnt[sel] < 65535) exp_cnt[sel]++;
      end
    end
  endtask

  initial begin
    logic        acc;
    logic        pv, ps;
    logic [31:0] pd;
    rst_n = 1'b0; in_valid = 1'b0; s = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    repeat (2) @(posedge clk);

    // Idle after reset, both select values
    cycle(0, 0, 0, 0, 0, 1, acc);
    cycle(0, 1, 0, 0, 0, 1, acc);

    // Back-to-back routing to both channels
    cycle(1, 0, 32'hA5A5A5A5, 1, 1, 1, acc);
    cycle(1, 1, 32'h5A5A5A5A, 1, 1, 1, acc);
    cycle(0, 0, 0, 1, 1, 1, acc);
    cycle(0, 0, 0, 1, 1, 1, acc);

    // Channel 1 fills and stalls; channel 0 keeps flowing
    cycle(1, 1, 32'h1, 1, 0, 1, acc);
    cycle(1, 1, 32'h2, 1, 0, 1, acc);
    cycle(1, 1, 32'h3, 1, 0, 1, acc);
    check("full_reject", {31'd0, acc}, 32'd0);
    cycle(1, 0, 32'h11, 1, 0, 1, acc);
    check("ch0_accept", {31'd0, acc}, 32'd1);
    repeat (3) cycle(0, 0, 0, 1, 1, 1, acc);

    // Push and pop together at count 1, then stream through the wrap
    cycle(1, 0, 32'h100, 0, 1, 1, acc);
    cycle(1, 0, 32'h101, 1, 1, 1, acc);
    check("pushpop_cnt", q0.size(), 32'd1);
    for (int i = 1; i <= 8; i++) cycle(1, 0, i, 1, 1, 1, acc);
    repeat (3) cycle(0, 0, 0, 1, 1, 1, acc);

    // Reset with both channels full
    for (int i = 0; i < 4; i++) cycle(1, i[0], 32'hDEAD0000 + i, 0, 0, 1, acc);
    cycle(0, 0, 0, 1, 1, 0, acc);
    cycle(0, 0, 0, 1, 1, 1, acc);
    cycle(0, 1, 0, 1, 1, 1, acc);

    // Counter scenario: 5 to channel 0, 3 to channel 1
    for (int i = 0; i < 5; i++) cycle(1, 0, 32'hC0 + i, 1, 1, 1, acc);
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'hC1 + i, 1, 1, 1, acc);
    cycle(0, 0, 0, 1, 1, 1, acc);

    // Random traffic; producer holds a refused word stable
    pv = 1'b0; ps = 1'b0; pd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        ps = $urandom_range(0, 1) == 1;
        pd = $urandom;
      end
      cycle(pv, ps, pd, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 99) != 0, acc);
      if (acc || !rst_n) pv = 1'b0;
    end

`ifdef DEMUX32_1_2_STATS_EN
    // Saturation from a preloaded 0xFFFE
    cycle(0, 0, 0, 1, 1, 1, acc);
    @(negedge clk);
    force dut.cnt0_q = 16'hFFFE;
    #1;
    release dut.cnt0_q;
    exp_cnt[0] = 16'hFFFE;
    for (int i = 0; i < 3; i++) cycle(1, 0, 32'hF0 + i, 1, 1, 1, acc);
    cycle(0, 0, 0, 1, 1, 1, acc);
    check("cnt0_sat", {16'd0, cnt0}, 32'h0000FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
